// File: rtl/ub_access_controller_if.sv
// Bundle of host-command, FIFO, compute and unified_buffer signals around ub_access_controller.
// slave = controller view, master = environment (host, FIFOs, compute unit, buffer).
interface ub_access_controller_if #(
  parameter int ADDRESS_SIZE = 10
);
  logic                    host_cmd_valid;
  logic                    host_cmd_ready;
  logic                    host_cmd_write;
  logic [ADDRESS_SIZE-1:0] host_cmd_addr;
  logic [ADDRESS_SIZE-1:0] host_cmd_len;
  logic                    host_busy;
  logic                    host_done;
  logic                    rx_empty;
  logic                    rx_pop;
  logic                    tx_full;
  logic                    tx_push;
  logic                    cmp_req;
  logic                    cmp_we;
  logic [ADDRESS_SIZE-1:0] cmp_addr;
  logic                    cmp_gnt;
  logic                    cmp_done;
  logic                    ub_we;
  logic                    ub_re;
  logic                    ub_compute_en;
  logic                    ub_fifo_en;
  logic                    ub_section;
  logic [ADDRESS_SIZE-1:0] ub_address;
  logic                    ub_done;

  modport slave (
    input  host_cmd_valid, host_cmd_write, host_cmd_addr, host_cmd_len,
    input  rx_empty, tx_full, cmp_req, cmp_we, cmp_addr, ub_done,
    output host_cmd_ready, host_busy, host_done, rx_pop, tx_push,
    output cmp_gnt, cmp_done, ub_we, ub_re, ub_compute_en, ub_fifo_en,
    output ub_section, ub_address
  );

  modport master (
    output host_cmd_valid, host_cmd_write, host_cmd_addr, host_cmd_len,
    output rx_empty, tx_full, cmp_req, cmp_we, cmp_addr, ub_done,
    input  host_cmd_ready, host_busy, host_done, rx_pop, tx_push,
    input  cmp_gnt, cmp_done, ub_we, ub_re, ub_compute_en, ub_fifo_en,
    input  ub_section, ub_address
  );
endinterface

// File: rtl/ub_access_controller.sv
// Arbitrates unified_buffer between host byte-pair bursts and single-word compute accesses,
// one outstanding buffer operation at a time, round-robin between host and compute.
module ub_access_controller #(
  parameter int BUFFER_SIZE  = 1024,
  parameter int ADDRESS_SIZE = $clog2(BUFFER_SIZE)
) (
  input logic                    clk,
  input logic                    rst_n,
  ub_access_controller_if.slave  bus
);

  typedef enum logic [1:0] {H_IDLE, H_ACTIVE, H_DONE} host_state_t;
  typedef enum logic {S_FREE, S_BUSY} slot_state_t;

  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(BUFFER_SIZE - 1);

  host_state_t             hstate;
  slot_state_t             slot;
  logic                    owner_host;
  logic                    last_host;
  logic                    hwrite;
  logic                    hsec;
  logic [ADDRESS_SIZE-1:0] haddr;
  logic [ADDRESS_SIZE-1:0] hcount;

  logic host_elig;
  logic issue_host;
  logic issue_cmp;
  logic done_cyc;

  always_comb begin
    host_elig  = (hstate == H_ACTIVE) && (hwrite ? !bus.rx_empty : !bus.tx_full);
    // Both eligible: the requester not served last wins.
    issue_host = (slot == S_FREE) && host_elig && (!bus.cmp_req || !last_host);
    issue_cmp  = (slot == S_FREE) && bus.cmp_req && !issue_host;
    done_cyc   = (slot == S_BUSY) && bus.ub_done;
  end

  always_comb begin
    bus.ub_we         = 1'b0;
    bus.ub_re         = 1'b0;
    bus.ub_fifo_en    = 1'b0;
    bus.ub_compute_en = 1'b0;
    bus.ub_section    = 1'b0;
    bus.ub_address    = '0;
    bus.rx_pop        = 1'b0;
    bus.cmp_gnt       = 1'b0;
    if (issue_host) begin
      bus.ub_we      = hwrite;
      bus.ub_re      = !hwrite;
      bus.ub_fifo_en = 1'b1;
      bus.ub_section = hsec;
      bus.ub_address = haddr;
      bus.rx_pop     = hwrite;
    end else if (issue_cmp) begin
      bus.ub_we         = bus.cmp_we;
      bus.ub_re         = !bus.cmp_we;
      bus.ub_compute_en = 1'b1;
      bus.ub_address    = bus.cmp_addr;
      bus.cmp_gnt       = 1'b1;
    end
    bus.tx_push  = done_cyc && owner_host && !hwrite;
    bus.cmp_done = done_cyc && !owner_host;
  end

  assign bus.host_cmd_ready = (hstate == H_IDLE);
  assign bus.host_busy      = (hstate == H_ACTIVE);
  assign bus.host_done      = (hstate == H_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hstate     <= H_IDLE;
      slot       <= S_FREE;
      owner_host <= 1'b0;
      last_host  <= 1'b0;
      hwrite     <= 1'b0;
      hsec       <= 1'b0;
      haddr      <= '0;
      hcount     <= '0;
    end else begin
      unique case (hstate)
        H_IDLE: begin
          if (bus.host_cmd_valid) begin
            hstate <= H_ACTIVE;
            hwrite <= bus.host_cmd_write;
            haddr  <= bus.host_cmd_addr;
            hcount <= bus.host_cmd_len;
            hsec   <= 1'b0;
          end
        end
        H_ACTIVE: begin
          // Byte sequencing advances on the buffer's done, not on issue.
          if (done_cyc && owner_host) begin
            if (!hsec) begin
              hsec <= 1'b1;
            end else begin
              hsec  <= 1'b0;
              haddr <= (haddr == LAST_ADDR) ? '0 : haddr + 1'b1;
              if (hcount == '0) hstate <= H_DONE;
              else              hcount <= hcount - 1'b1;
            end
          end
        end
        H_DONE:  hstate <= H_IDLE;
        default: hstate <= H_IDLE;
      endcase

      unique case (slot)
        S_FREE: begin
          if (issue_host || issue_cmp) begin
            slot       <= S_BUSY;
            owner_host <= issue_host;
            last_host  <= issue_host;
          end
        end
        S_BUSY:  if (bus.ub_done) slot <= S_FREE;
        default: slot <= S_FREE;
      endcase
    end
  end

endmodule
